viterbi_frame_ctrl: RTL and testbench
=====================================

Name: viterbi_frame_ctrl

Overview:
Frame sequencer for the Viterbi decoder datapath. It accepts received bit pairs over a valid/ready handshake and forwards them to the branch metric units. It marks stage 0 so that it is routed to first_bmu, and pulses the BMU refresh at each frame start. After the last symbol it waits for the ACS pipeline to drain, triggers traceback, and signals frame completion. Sits between the channel input interface and the BMU/ACS/traceback blocks.

Parameters:
FRAME_LEN, 16, maximum symbols per frame; the frame closes automatically after this many.
CNT_W, 5, width of the stage counter; must satisfy 2^CNT_W > FRAME_LEN.
PIPE_LAT, 2, cycles to wait after the last symbol before traceback starts (BMU+ACS drain).
TB_TIMEOUT, 64, maximum cycles to wait for tb_done.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  input symbol valid
in_ready  out  1  controller can accept a symbol
bit_pair_in  in  2  received bit pair
in_last  in  1  accepted symbol is the last of the frame
bmu_bit_pair  out  2  registered bit pair to BMUs
bmu_sym_valid  out  1  bmu_bit_pair valid this cycle
bmu_first  out  1  current symbol is stage 0 (route to first_bmu)
bmu_refresh  out  1  clear BMU/ACS metrics
stage_idx  out  CNT_W  stage index of current bmu_bit_pair
tb_start  out  1  one-cycle traceback start pulse
tb_done  in  1  traceback complete
busy  out  1  state != IDLE
frame_done  out  1  one-cycle end-of-frame pulse
tb_error  out  1  sticky traceback timeout flag

Behaviour:
- States: IDLE, RUN, DRAIN, TRACE, DONE.
- Reset (rst=1 at a clock edge, any state, including mid-frame): state=IDLE; counters=0; all outputs=0 except in_ready=1; tb_error cleared.
- Accept = in_valid && in_ready. in_ready=1 only in IDLE and RUN.
- Accept at edge N: in the cycle after N, bmu_bit_pair=bit_pair_in, bmu_sym_valid=1, and stage_idx=stage count before increment. Latency is one cycle. Without an accept at edge N, bmu_sym_valid=0 after N and bmu_bit_pair holds its value.
- IDLE -> RUN on accept: stage count=0; bmu_first=1 and bmu_refresh=1 in the same cycle as that symbol's bmu_sym_valid, otherwise 0.
- RUN: each accept increments the stage count. Accepted symbols need not be consecutive; gaps leave the stage count unchanged.
- Frame close: an accept with in_last=1, or the FRAME_LEN-th accept (stage_idx=FRAME_LEN-1), moves to DRAIN. This applies also to the IDLE accept, so a 1-symbol frame goes IDLE->DRAIN. in_ready=0 from the cycle after the close.
- DRAIN: count PIPE_LAT cycles, then go to TRACE. tb_start=1 for exactly the first TRACE cycle.
- TRACE: tb_done is sampled from the cycle after tb_start; tb_done coincident with tb_start is ignored.
  - tb_done=1 -> DONE.
  - TB_TIMEOUT cycles without tb_done -> tb_error=1 (sticky until rst), then DONE.
- DONE: frame_done=1 for one cycle, then IDLE with counters cleared. in_ready is 0 in DONE, so the next frame's first accept can occur at the earliest one cycle after frame_done.
- busy=1 in RUN/DRAIN/TRACE/DONE.
- Counter arithmetic: unsigned, CNT_W bits; wrap cannot occur because of the FRAME_LEN close.

Test Plan:
1. rst held 2 cycles mid-RUN (stage 5) -> next cycle busy=0, in_ready=1, stage_idx=0, bmu_sym_valid=0, tb_error=0.
2. 4 back-to-back accepts (00,01,10,11), last with in_last=1 -> bmu_bit_pair 00/01/10/11 on consecutive cycles, stage_idx 0..3. bmu_first=bmu_refresh=1 only with 00. tb_start 3 cycles after the last bmu_sym_valid (PIPE_LAT=2 drain plus one cycle); tb_done 5 cycles later -> frame_done one cycle after.
3. 16 accepts with in_last=0 and FRAME_LEN=16 -> in_ready=0 after the 16th; 17th in_valid is held off; stage_idx max 15; tb_start follows.
4. Symbols with in_valid gaps of 3 cycles -> bmu_sym_valid only on accepted cycles; stage_idx has no gaps; bmu_refresh pulses once.
5. tb_done never asserted -> tb_error=1 after 64 TRACE cycles, frame_done pulses, IDLE. The next frame runs normally with tb_error still 1 until rst.
6. Single symbol 11 with in_last=1 from IDLE -> bmu_first=1, bmu_refresh=1, stage_idx=0, DRAIN entered; tb_done asserted in the tb_start cycle is ignored, and a second tb_done one cycle later completes the frame.

Source files
------------

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the Viterbi datapath: forwards received bit pairs to the BMUs,
// marks stage 0, then drains the ACS pipeline, runs traceback and reports frame completion.
module viterbi_frame_ctrl #(
    parameter int unsigned FRAME_LEN  = 16,
    parameter int unsigned CNT_W      = 5,
    parameter int unsigned PIPE_LAT   = 2,
    parameter int unsigned TB_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       bit_pair_in,
    input  logic             in_last,
    output logic [1:0]       bmu_bit_pair,
    output logic             bmu_sym_valid,
    output logic             bmu_first,
    output logic             bmu_refresh,
    output logic [CNT_W-1:0] stage_idx,
    output logic             tb_start,
    input  logic             tb_done,
    output logic             busy,
    output logic             frame_done,
    output logic             tb_error
);

    localparam int unsigned DRAIN_W = $clog2(PIPE_LAT + 2);
    localparam int unsigned TO_W    = $clog2(TB_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_TRACE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state;
    state_t next_state;

    logic [CNT_W-1:0]   stage_cnt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [TO_W-1:0]    trace_cnt;

    logic               accept_c;
    logic               close_c;
    logic               done_seen_c;
    logic               timeout_c;

    logic               in_ready_d;
    logic               busy_d;
    logic               sym_valid_d;
    logic               first_d;
    logic               refresh_d;
    logic [1:0]         bit_pair_d;
    logic [CNT_W-1:0]   stage_idx_d;
    logic               tb_start_d;
    logic               frame_done_d;
    logic               tb_error_d;
    logic [CNT_W-1:0]   stage_cnt_d;
    logic [DRAIN_W-1:0] drain_cnt_d;
    logic [TO_W-1:0]    trace_cnt_d;

    // The first TRACE cycle is the one carrying tb_start; tb_done there is ignored.
    always_comb begin
        accept_c    = in_valid && in_ready;
        close_c     = accept_c && (in_last || (stage_cnt == CNT_W'(FRAME_LEN - 1)));
        done_seen_c = (state == S_TRACE) && !tb_start && tb_done;
        timeout_c   = (state == S_TRACE) && !tb_start && !tb_done &&
                      (trace_cnt == TO_W'(TB_TIMEOUT - 1));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept_c) begin
                    next_state = close_c ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                if (close_c) begin
                    next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == DRAIN_W'(PIPE_LAT)) begin
                    next_state = S_TRACE;
                end
            end
            S_TRACE: begin
                if (done_seen_c || timeout_c) begin
                    next_state = S_DONE;
                end
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Output and counter next values; everything is registered below
    always_comb begin
        in_ready_d   = 1'b0;
        busy_d       = 1'b0;
        sym_valid_d  = 1'b0;
        first_d      = 1'b0;
        refresh_d    = 1'b0;
        bit_pair_d   = bmu_bit_pair;
        stage_idx_d  = stage_idx;
        tb_start_d   = 1'b0;
        frame_done_d = 1'b0;
        tb_error_d   = tb_error;
        stage_cnt_d  = stage_cnt;
        drain_cnt_d  = '0;
        trace_cnt_d  = '0;

        in_ready_d   = (next_state == S_IDLE) || (next_state == S_RUN);
        busy_d       = (next_state != S_IDLE);
        sym_valid_d  = accept_c;
        first_d      = accept_c && (state == S_IDLE);
        refresh_d    = accept_c && (state == S_IDLE);
        tb_start_d   = (state == S_DRAIN) && (next_state == S_TRACE);
        frame_done_d = (state == S_TRACE) && (next_state == S_DONE);
        tb_error_d   = tb_error || timeout_c;

        if (accept_c) begin
            bit_pair_d  = bit_pair_in;
            stage_idx_d = stage_cnt;
            stage_cnt_d = stage_cnt + CNT_W'(1);
        end else if (next_state == S_IDLE) begin
            stage_cnt_d = '0;
        end

        if (state == S_DRAIN) begin
            drain_cnt_d = drain_cnt + DRAIN_W'(1);
        end
        if (state == S_TRACE) begin
            trace_cnt_d = trace_cnt + TO_W'(1);
        end
    end

    // Output and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready      <= 1'b1;
            busy          <= 1'b0;
            bmu_sym_valid <= 1'b0;
            bmu_first     <= 1'b0;
            bmu_refresh   <= 1'b0;
            bmu_bit_pair  <= '0;
            stage_idx     <= '0;
            tb_start      <= 1'b0;
            frame_done    <= 1'b0;
            tb_error      <= 1'b0;
            stage_cnt     <= '0;
            drain_cnt     <= '0;
            trace_cnt     <= '0;
        end else begin
            in_ready      <= in_ready_d;
            busy          <= busy_d;
            bmu_sym_valid <= sym_valid_d;
            bmu_first     <= first_d;
            bmu_refresh   <= refresh_d;
            bmu_bit_pair  <= bit_pair_d;
            stage_idx     <= stage_idx_d;
            tb_start      <= tb_start_d;
            frame_done    <= frame_done_d;
            tb_error      <= tb_error_d;
            stage_cnt     <= stage_cnt_d;
            drain_cnt     <= drain_cnt_d;
            trace_cnt     <= trace_cnt_d;
        end
    end

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Bench for viterbi_frame_ctrl: directed and randomized frames checked against
// frame-level expectations (symbol order, stage numbering, drain/traceback timing).
module tb_viterbi_frame_ctrl;

    localparam int unsigned FRAME_LEN  = 16;
    localparam int unsigned CNT_W      = 5;
    localparam int unsigned PIPE_LAT   = 2;
    localparam int unsigned TB_TIMEOUT = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       bit_pair_in;
    logic             in_last;
    logic [1:0]       bmu_bit_pair;
    logic             bmu_sym_valid;
    logic             bmu_first;
    logic             bmu_refresh;
    logic [CNT_W-1:0] stage_idx;
    logic             tb_start;
    logic             tb_done;
    logic             busy;
    logic             frame_done;
    logic             tb_error;

    int               checks = 0;
    int               errors = 0;
    logic             exp_err;
    logic [1:0]       last_pair;
    int               refresh_seen;

    viterbi_frame_ctrl #(
        .FRAME_LEN (FRAME_LEN),
        .CNT_W     (CNT_W),
        .PIPE_LAT  (PIPE_LAT),
        .TB_TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .bit_pair_in  (bit_pair_in),
        .in_last      (in_last),
        .bmu_bit_pair (bmu_bit_pair),
        .bmu_sym_valid(bmu_sym_valid),
        .bmu_first    (bmu_first),
        .bmu_refresh  (bmu_refresh),
        .stage_idx    (stage_idx),
        .tb_start     (tb_start),
        .tb_done      (tb_done),
        .busy         (busy),
        .frame_done   (frame_done),
        .tb_error     (tb_error)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_v(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk_b({tag, "_in_ready"}, in_ready, 1'b1);
        chk_b({tag, "_busy"}, busy, 1'b0);
        chk_b({tag, "_sym_valid"}, bmu_sym_valid, 1'b0);
        chk_b({tag, "_first"}, bmu_first, 1'b0);
        chk_b({tag, "_refresh"}, bmu_refresh, 1'b0);
        chk_v({tag, "_stage_idx"}, 32'(stage_idx), 32'd0);
        chk_v({tag, "_bit_pair"}, 32'(bmu_bit_pair), 32'd0);
        chk_b({tag, "_tb_start"}, tb_start, 1'b0);
        chk_b({tag, "_frame_done"}, frame_done, 1'b0);
        chk_b({tag, "_tb_error"}, tb_error, 1'b0);
    endtask

    // pat: 0 random pairs, 1 pair = stage index, 2 all 11.
    // done_lat: TRACE cycle (counted from the tb_start cycle) in which tb_done is raised, -1 never.
    task automatic run_frame(input int n_sym, input bit mark_last, input int gap_min,
                             input int gap_max, input int pat, input int done_lat,
                             input bit early_done);
        int         exp_len;
        int         gap;
        bit         fin;
        logic [1:0] p;
        exp_len      = (mark_last && n_sym < int'(FRAME_LEN)) ? n_sym : int'(FRAME_LEN);
        refresh_seen = 0;
        for (int k = 0; k < exp_len; k++) begin
            gap = int'($urandom_range(gap_max, gap_min));
            for (int g = 0; g < gap; g++) begin
                in_valid    = 1'b0;
                bit_pair_in = 2'($urandom);
                in_last     = 1'($urandom);
                step();
                chk_b("gap_sym_valid", bmu_sym_valid, 1'b0);
                chk_v("gap_pair_hold", 32'(bmu_bit_pair), 32'(last_pair));
                chk_b("gap_in_ready", in_ready, 1'b1);
                chk_b("gap_busy", busy, k > 0);
                if (bmu_refresh) refresh_seen++;
            end
            case (pat)
                1:       p = 2'(k);
                2:       p = 2'b11;
                default: p = 2'($urandom);
            endcase
            in_valid    = 1'b1;
            bit_pair_in = p;
            in_last     = mark_last && (k == n_sym - 1);
            step();
            last_pair = p;
            chk_b("sym_valid", bmu_sym_valid, 1'b1);
            chk_v("bit_pair", 32'(bmu_bit_pair), 32'(p));
            chk_v("stage_idx", 32'(stage_idx), 32'(k));
            chk_b("bmu_first", bmu_first, k == 0);
            chk_b("bmu_refresh", bmu_refresh, k == 0);
            chk_b("run_busy", busy, 1'b1);
            chk_b("run_in_ready", in_ready, k != exp_len - 1);
            if (bmu_refresh) refresh_seen++;
        end
        // Drain: offered symbols must be held off
        for (int d = 1; d <= int'(PIPE_LAT) + 1; d++) begin
            in_valid    = (n_sym > exp_len) ? 1'b1 : 1'($urandom);
            bit_pair_in = 2'($urandom);
            in_last     = 1'b0;
            step();
            chk_b("drain_sym_valid", bmu_sym_valid, 1'b0);
            chk_v("drain_pair_hold", 32'(bmu_bit_pair), 32'(last_pair));
            chk_b("drain_in_ready", in_ready, 1'b0);
            chk_b("drain_busy", busy, 1'b1);
            chk_b("tb_start", tb_start, d == int'(PIPE_LAT) + 1);
            chk_b("drain_frame_done", frame_done, 1'b0);
            if (bmu_refresh) refresh_seen++;
        end
        chk_v("refresh_once", 32'(refresh_seen), 32'd1);
        // Traceback: loop index t is the TRACE cycle in which tb_done is driven
        fin = 1'b0;
        for (int t = 0; t < int'(TB_TIMEOUT) + 4 && !fin; t++) begin
            tb_done  = (t == 0) ? early_done : (t == done_lat);
            in_valid = 1'($urandom);
            step();
            if (t >= 1 && t == done_lat) begin
                fin = 1'b1;
            end else if (t == int'(TB_TIMEOUT) - 1) begin
                fin     = 1'b1;
                exp_err = 1'b1;
            end
            chk_b("frame_done", frame_done, fin);
            chk_b("trace_tb_start", tb_start, 1'b0);
            chk_b("tb_error", tb_error, exp_err);
            chk_b("trace_busy", busy, 1'b1);
            chk_b("trace_in_ready", in_ready, 1'b0);
            chk_b("trace_sym_valid", bmu_sym_valid, 1'b0);
        end
        chk_b("trace_finished", fin, 1'b1);
        tb_done  = 1'b0;
        in_valid = 1'b0;
        step();
        chk_b("idle_frame_done", frame_done, 1'b0);
        chk_b("idle_busy", busy, 1'b0);
        chk_b("idle_in_ready", in_ready, 1'b1);
        chk_b("idle_tb_error", tb_error, exp_err);
        chk_b("idle_sym_valid", bmu_sym_valid, 1'b0);
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        bit_pair_in = 2'b00;
        in_last     = 1'b0;
        tb_done     = 1'b0;
        exp_err     = 1'b0;
        last_pair   = 2'b00;
        step();
        step();
        chk_reset_state("por");
        rst = 1'b0;
        step();
        chk_reset_state("por_idle");

        // Reset while mid-frame at stage 5
        for (int k = 0; k < 6; k++) begin
            in_valid    = 1'b1;
            bit_pair_in = 2'($urandom);
            in_last     = 1'b0;
            step();
        end
        chk_v("pre_rst_stage", 32'(stage_idx), 32'd5);
        chk_b("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        step();
        step();
        chk_reset_state("mid_rst");
        rst      = 1'b0;
        in_valid = 1'b0;
        step();
        chk_reset_state("mid_rst_idle");
        last_pair = 2'b00;
        exp_err   = 1'b0;

        run_frame(4, 1'b1, 0, 0, 1, 5, 1'b0);    // 00,01,10,11 back-to-back
        run_frame(17, 1'b0, 0, 0, 0, 3, 1'b0);   // FRAME_LEN close, 17th held off
        run_frame(5, 1'b1, 3, 3, 0, 2, 1'b0);    // 3-cycle gaps
        run_frame(3, 1'b1, 0, 1, 0, -1, 1'b0);   // traceback timeout
        run_frame(6, 1'b1, 0, 2, 0, 4, 1'b0);    // normal frame, error stays sticky
        run_frame(1, 1'b1, 0, 0, 2, 1, 1'b1);    // single symbol, early tb_done ignored

        for (int i = 0; i < 10; i++) begin
            run_frame(int'($urandom_range(20, 1)), ($urandom_range(3, 0) != 0), 0, 2, 0,
                      int'($urandom_range(12, 1)), 1'($urandom));
        end

        rst = 1'b1;
        step();
        chk_reset_state("final_rst");
        rst     = 1'b0;
        exp_err = 1'b0;
        step();
        chk_b("final_tb_error", tb_error, exp_err);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
